// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide registered-read RAM: byte/half/word access, alignment check,
// load extension and read-modify-write sub-word stores. Build option: MEM_RANGE_CHK_EN.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_data,
  output logic              o_ram_we,
  input  logic [31:0]       i_ram_data
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                wr_r;
  logic [1:0]          size_r;
  logic                sext_r;
  logic [1:0]          off_r;
  logic [15:0]         wdata_r;
  logic                err_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [31:0]         ram_data_r;
  logic [31:0]         rdata_r;
  logic                bad_s;

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract_lane = {{24{sext & b[7]}}, b};
      2'b01:   extract_lane = {{16{sext & h[15]}}, h};
      default: extract_lane = word;
    endcase
  endfunction

  // Overwrite only the addressed lane of the old word with the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    merge_lane = word;
    case (size)
      2'b00:   merge_lane[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   merge_lane[{off[1], 4'b0000} +: 16] = wdata;
      default: merge_lane = word;
    endcase
  endfunction

  // Request legality: alignment, reserved size and (optionally) out-of-range address.
  always_comb begin
    bad_s = 1'b0;
    case (i_size)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = i_addr[0];
      2'b10:   bad_s = (i_addr[1:0] != 2'b00);
      default: bad_s = 1'b1;
    endcase
`ifdef MEM_RANGE_CHK_EN
    bad_s = bad_s | (|i_addr[31:ADDR_W+2]);
`endif
  end

`ifndef MEM_RANGE_CHK_EN
  // High address bits alias away when range checking is not built in.
  logic unused_hi_addr_s;
  assign unused_hi_addr_s = ^i_addr[31:ADDR_W+2];
`endif

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!i_req) begin
          state_s = ST_IDLE;
        end else if (bad_s) begin
          state_s = ST_RESP;
        end else if (i_wr && (i_size == 2'b10)) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RD:   state_s = ST_CAP;
      ST_CAP:  state_s = wr_r ? ST_WR : ST_RESP;
      ST_WR:   state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, RAM address/data drive and load result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_r       <= 1'b0;
      size_r     <= 2'b00;
      sext_r     <= 1'b0;
      off_r      <= 2'b00;
      wdata_r    <= 16'h0000;
      err_r      <= 1'b0;
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_data_r <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_req) begin
            wr_r    <= i_wr;
            size_r  <= i_size;
            sext_r  <= i_sign_ext;
            off_r   <= i_addr[1:0];
            wdata_r <= i_wdata[15:0];
            err_r   <= bad_s;
            // Rejected requests leave the RAM-side registers untouched.
            if (!bad_s) begin
              ram_addr_r <= i_addr[ADDR_W+1:2];
              if (i_wr) begin
                ram_data_r <= i_wdata;
              end
            end
          end
        end
        ST_CAP: begin
          if (wr_r) begin
            ram_data_r <= merge_lane(i_ram_data, wdata_r, size_r, off_r);
          end else begin
            rdata_r <= extract_lane(i_ram_data, size_r, off_r, sext_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ready    = (state_r == ST_IDLE);
  assign o_done     = (state_r == ST_RESP);
  assign o_err      = (state_r == ST_RESP) & err_r;
  assign o_ram_we   = (state_r == ST_WR);
  assign o_ram_addr = ram_addr_r;
  assign o_ram_data = ram_data_r;
  assign o_rdata    = rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model of the unit plus a word RAM,
// checked every cycle, with hand-computed literals pinning selected results.
module tb_mem_access_unit;

  localparam int ADDR_W = 5;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_req;
  logic              i_wr;
  logic [1:0]        i_size;
  logic              i_sign_ext;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic              o_done;
  logic              o_err;
  logic [31:0]       o_rdata;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [31:0]       o_ram_data;
  logic              o_ram_we;
  logic [31:0]       i_ram_data;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr), .i_size(i_size),
    .i_sign_ext(i_sign_ext), .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .o_ram_we(o_ram_we), .i_ram_data(i_ram_data)
  );

  always #5 i_clk = ~i_clk;

  // Word RAM with registered read.
  bit [31:0] ram [32];
  bit [31:0] ram_q;
  always @(posedge i_clk) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
    ram_q <= ram[o_ram_addr];
  end
  assign i_ram_data = ram_q;

  int n_chk  = 0;
  int n_pass = 0;

  // Literal expectation for the transaction in flight: 0 none, 1 rdata, 2 RAM word, 3 error.
  int          lit_kind = 0;
  int          lit_idx  = 0;
  logic [31:0] lit_val  = 32'h0;

  // Model state.
  bit [31:0]   ref_mem [32];
  logic [31:0] mdl_rdata = 32'h0;
  bit          busy = 1'b0;
  int          k = 0, lat = 0, wcyc = -1, widx = 0, sh = 0;
  bit          m_err = 1'b0, m_load = 1'b0, m_misal;
  logic [31:0] ld_val, wr_word, mask, v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Compare process: predicts every output from the request stream and checks it each cycle.
  always @(negedge i_clk) begin
    bit done_now;
    done_now = 1'b0;
    if (!i_rst_n) begin
      busy = 1'b0;
      mdl_rdata = 32'h0;
      chk("rst_ready", {31'b0, o_ready}, 32'd1);
      chk("rst_done", {31'b0, o_done}, 32'd0);
      chk("rst_err", {31'b0, o_err}, 32'd0);
      chk("rst_we", {31'b0, o_ram_we}, 32'd0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_ram_addr", {27'b0, o_ram_addr}, 32'd0);
      chk("rst_ram_data", o_ram_data, 32'h0);
    end else begin
      if (busy) k++;
      done_now = busy && (k == lat);
      if (done_now && m_load) mdl_rdata = ld_val;
      chk("ready", {31'b0, o_ready}, {31'b0, !busy});
      chk("done", {31'b0, o_done}, {31'b0, done_now});
      chk("ram_we", {31'b0, o_ram_we}, {31'b0, busy && (k == wcyc)});
      chk("rdata", o_rdata, mdl_rdata);
      if (busy && (k == wcyc)) begin
        chk("ram_addr", {27'b0, o_ram_addr}, widx);
        chk("ram_data", o_ram_data, wr_word);
        ref_mem[widx] = wr_word;
      end
      if (done_now) begin
        chk("err", {31'b0, o_err}, {31'b0, m_err});
        if (!m_err && !m_load) chk("ram_word", ram[widx], ref_mem[widx]);
        case (lit_kind)
          1: begin chk("lit_rdata", o_rdata, lit_val); chk("lit_noerr", {31'b0, o_err}, 32'd0); end
          2: begin chk("lit_ram", ram[lit_idx], lit_val); chk("lit_noerr", {31'b0, o_err}, 32'd0); end
          3: chk("lit_err", {31'b0, o_err}, 32'd1);
          default: ;
        endcase
        busy = 1'b0;
      end else if (!busy && i_req) begin
        // Accepted at the coming edge: derive latency, write timing and result.
        m_misal = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) ||
                  (i_size == 2'b10 && i_addr[1:0] != 2'b00);
`ifdef MEM_RANGE_CHK_EN
        m_misal = m_misal || (i_addr[31:ADDR_W+2] != 0);
`endif
        widx = int'(i_addr[ADDR_W+1:2]);
        sh   = 8 * int'(i_addr[1:0]);
        mask = (i_size == 2'b00) ? 32'hFF : (i_size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        busy = 1'b1;
        k = 0;
        wcyc = -1;
        m_load = 1'b0;
        m_err = m_misal;
        if (m_misal) begin
          lat = 1;
        end else if (i_wr) begin
          lat = (i_size == 2'b10) ? 2 : 4;
          wcyc = lat - 1;
          wr_word = (ref_mem[widx] & ~(mask << sh)) | ((i_wdata & mask) << sh);
        end else begin
          lat = 3;
          m_load = 1'b1;
          v = (ref_mem[widx] >> sh) & mask;
          if (i_sign_ext && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
          ld_val = v;
        end
      end
    end
  end

  // Issue one request at posedge+2 with the unit idle; scramble inputs while it runs.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int kind, input int idx, input logic [31:0] val);
    bit got;
    lit_kind = kind; lit_idx = idx; lit_val = val;
    i_req = 1'b1; i_wr = wr; i_size = size; i_sign_ext = sext; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk); #2;
    i_wr = ~wr; i_size = ~size; i_sign_ext = ~sext; i_addr = $urandom; i_wdata = $urandom;
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    i_req = 1'b0;
    if (!got) begin
      $display("FAIL timeout: no o_done for addr %h, got none expected one within 8 cycles", addr);
      $fatal(1, "no completion");
    end
    @(posedge i_clk); #2;
    lit_kind = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_wr = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #2;

    do_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h80A1B2C3, 2, 3, 32'h80A1B2C3);
    do_req(1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, 1, 0, 32'hFFFFFFC3);
    do_req(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 1, 0, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 1, 0, 32'hFFFF80A1);
    do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234BEEF, 2, 3, 32'hBEEFB2C3);
    do_req(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 1, 0, 32'h0000B2C3);
    do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 1, 0, 32'hFFFFFFB2);
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1, 0, 32'hBEEFB2C3);
    do_req(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, 3, 0, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h0A, 32'hFFFFFFFF, 3, 0, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 3, 0, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h01, 32'hFFFFFFAA, 2, 0, 32'h0000AA00);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 4, 32'h11223344);

    // Byte store to word 4, aborted by reset while the read word is being captured.
    i_req = 1'b1; i_wr = 1'b1; i_size = 2'b00; i_sign_ext = 1'b0; i_addr = 32'h10; i_wdata = 32'h55;
    @(posedge i_clk); #2;
    i_req = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #2;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0, 32'h11223344);

    do_req(1'b1, 2'b10, 1'b0, 32'h00, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF);
`ifdef MEM_RANGE_CHK_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 3, 0, 32'h0);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1, 0, 32'hDEADBEEF);
`endif
    do_req(1'b0, 2'b00, 1'b0, 32'h02, 32'h0, 1, 0, 32'h000000AD);

    repeat (2) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the CPU datapath and the 32x32-bit word RAM (`ram`).
- Accepts byte, halfword and word requests at byte addresses and checks alignment.
- Performs loads with sign or zero extension.
- Performs sub-word stores as read-modify-write, because the RAM has only a whole-word write enable.
- Drives the RAM's address, data and write-enable ports directly and consumes its read data.

Parameters:
- ADDR_W, 5, RAM word-address width; the RAM depth is 2**ADDR_W words.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  request strobe; sampled only while o_ready=1.
- i_wr  input  1  1=store, 0=load.
- i_size  input  2  00=byte, 01=half, 10=word, 11=reserved (flagged as error).
- i_sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend.
- i_addr  input  32  byte address.
- i_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_ready  output  1  unit idle and able to accept a request.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  error flag; valid only while o_done=1.
- o_rdata  output  32  load result.
- o_ram_addr  output  ADDR_W  word address to the RAM = latched addr[ADDR_W+1:2].
- o_ram_data  output  32  write data to the RAM.
- o_ram_we  output  1  RAM write enable.
- i_ram_data  input  32  RAM read data; valid the cycle after the address is applied (registered read).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_ready=1; o_done=0; o_err=0; o_rdata=0; o_ram_we=0; o_ram_addr=0; o_ram_data=0.
  - o_ram_we is decoded from the state register, so it drops immediately on reset.
- Byte lanes are little-endian: byte k (addr[1:0]=k) occupies bits [8k+7:8k]; a halfword at addr[1]=h occupies [16h+15:16h].
- IDLE (o_ready=1): on i_req=1, latch wr, size, sign_ext, addr and wdata. Next state:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1; no RAM access.
  - word store -> WR.
  - load or sub-word store -> RD.
- RD: drive o_ram_addr -> CAP.
- CAP: i_ram_data is valid.
  - Load: extract the lane, extend per sign_ext, register into o_rdata -> RESP.
  - Sub-word store: merge the wdata lane into the read word and hold it in the write buffer -> WR.
- WR: o_ram_we=1 with o_ram_addr and o_ram_data = write buffer (wdata for word stores) for exactly one cycle -> RESP.
- RESP: o_done=1; o_err = latched error flag -> IDLE.
- Latency, counted in cycles after the accept edge, with o_done high in that cycle:
  - misaligned: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Throughput: o_ready=0 in every state except IDLE. A new request can be accepted in the cycle after RESP.
- i_req while o_ready=0 is ignored: not queued, not latched.
- Inputs may change freely after the accept edge; only latched copies are used.
- o_rdata holds its value until the next successful load. Stores and errors never modify o_rdata.
- o_ram_addr and o_ram_data hold their last value in IDLE. o_ram_we=1 only in WR.
- Address bits above ADDR_W+1 are ignored: addresses alias modulo 4*2**ADDR_W bytes (unless range checking is compiled in, see below).
- Reset mid-operation aborts the request with no write. If reset occurs during WR, o_ram_we drops asynchronously; whether that edge's write lands depends on clock/reset timing and is not guaranteed.

Optional Feature:
- Macro: MEM_RANGE_CHK_EN.
- Defined: in IDLE, any request with nonzero i_addr[31:ADDR_W+2] is treated like a misaligned access -> RESP with o_err=1 after 1 cycle, no RAM access.
- Undefined: high address bits are ignored and accesses alias.

Test Plan:
- Word store, addr=0x0C, wdata=0x80A1B2C3 -> o_ram_we high in cycle 1 with o_ram_addr=3; o_done in cycle 2, o_err=0; ram word 3 = 0x80A1B2C3.
- Byte load, signed, addr=0x0C -> o_done in cycle 3; o_rdata=0xFFFFFFC3. Unsigned byte at addr=0x0F -> o_rdata=0x00000080. Signed half at addr=0x0E -> 0xFFFF80A1.
- Half store, addr=0x0E, wdata=0x1234BEEF -> o_done in cycle 4; word 3 = 0xBEEFB2C3; other words unchanged.
- Half load at 0x0D, then word store at 0x0A -> each gives o_done after 1 cycle with o_err=1; o_ram_we never asserted; o_rdata unchanged.
- Byte store at 0x10, i_rst_n pulsed low while in CAP -> o_ram_we stays 0; word 4 unchanged; o_ready=1 and o_done=0 immediately.
- With MEM_RANGE_CHK_EN: word load at 0x80 -> o_err=1 after 1 cycle. Without it: same request returns word 0 after 3 cycles.
